// File: rtl/uart_rx_fifo.sv
// Byte FIFO between uart_rx and the memory-map decoder (data 0x400, status 0x401).
// Optional flow control (O_rts with hysteresis) when UART_RX_FIFO_FLOW_EN is defined.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_THRESH  = 12
) (
  input  logic                  I_clk,
  input  logic                  I_reset,
  input  logic                  I_wr,
  input  logic [7:0]            I_data,
  input  logic                  I_rd,
  input  logic                  I_flush,
  input  logic                  I_clr_ovf,
  output logic [7:0]            O_data,
  output logic                  O_data_valid,
  output logic                  O_empty,
  output logic                  O_full,
  output logic                  O_almost_full,
  output logic [DEPTH_LOG2:0]   O_count,
`ifdef UART_RX_FIFO_FLOW_EN
  output logic                  O_rts,
`endif
  output logic                  O_overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int PW    = DEPTH_LOG2;

  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF   = CW'(AF_THRESH);
  localparam logic [PW-1:0] P_ONE  = PW'(1);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          do_wr;
  logic          do_rd;
  logic          drop;
  logic [CW-1:0] count_nx;

  // When full, a same-cycle read frees the slot the write lands in.
  always_comb begin
    do_rd    = I_rd & ~O_empty;
    do_wr    = I_wr & (~O_full | I_rd);
    drop     = I_wr & O_full & ~I_rd;
    count_nx = O_count;
    unique case ({do_wr, do_rd})
      2'b10:   count_nx = O_count + C_ONE;
      2'b01:   count_nx = O_count - C_ONE;
      default: count_nx = O_count;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (do_wr && !I_flush && !I_reset) begin
      mem[wr_ptr] <= I_data;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      O_count       <= '0;
      O_empty       <= 1'b1;
      O_full        <= 1'b0;
      O_almost_full <= 1'b0;
      O_overflow    <= 1'b0;
      O_data        <= 8'h00;
      O_data_valid  <= 1'b0;
    end else if (I_flush) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      O_count       <= '0;
      O_empty       <= 1'b1;
      O_full        <= 1'b0;
      O_almost_full <= 1'b0;
      O_data_valid  <= 1'b0;
      if (I_clr_ovf) begin
        O_overflow <= 1'b0;
      end
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + P_ONE;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + P_ONE;
      end
      if (I_rd) begin
        O_data <= do_rd ? mem[rd_ptr] : 8'h00;
      end
      O_data_valid  <= I_rd;
      O_count       <= count_nx;
      O_empty       <= (count_nx == '0);
      O_full        <= (count_nx == C_FULL);
      O_almost_full <= (count_nx >= C_AF);
      // A dropping write in the same cycle beats the clear.
      if (drop) begin
        O_overflow <= 1'b1;
      end else if (I_clr_ovf) begin
        O_overflow <= 1'b0;
      end
    end
  end

`ifdef UART_RX_FIFO_FLOW_EN
  localparam logic [CW-1:0] C_LOW = CW'(AF_THRESH / 2);

  logic [CW-1:0] level_nx;

  always_comb begin
    level_nx = I_flush ? '0 : count_nx;
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      O_rts <= 1'b0;
    end else if (level_nx >= C_AF) begin
      O_rts <= 1'b1;
    end else if (level_nx <= C_LOW) begin
      O_rts <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: read expectations go through a
// scoreboard queue checked by an independent monitor on O_data_valid.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr;
  logic [7:0] din;
  logic       rd;
  logic       flush;
  logic       clr_ovf;
  logic [7:0] dout;
  logic       dvalid;
  logic       empty;
  logic       full;
  logic       afull;
  logic [4:0] count;
  logic       ovf;
`ifdef UART_RX_FIFO_FLOW_EN
  logic       rts;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  exp_t q[$];

  uart_rx_fifo #(.DEPTH_LOG2(4), .AF_THRESH(12)) dut (
    .I_clk        (clk),
    .I_reset      (reset),
    .I_wr         (wr),
    .I_data       (din),
    .I_rd         (rd),
    .I_flush      (flush),
    .I_clr_ovf    (clr_ovf),
    .O_data       (dout),
    .O_data_valid (dvalid),
    .O_empty      (empty),
    .O_full       (full),
    .O_almost_full(afull),
    .O_count      (count),
`ifdef UART_RX_FIFO_FLOW_EN
    .O_rts        (rts),
`endif
    .O_overflow   (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endfunction

  // Monitor: every valid pulse must match the oldest pending read.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].c < cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_valid due_cycle=%0d now=%0d", q[0].c, cyc);
      void'(q.pop_front());
    end
    if (dvalid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=1 expected=0");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rd_data", int'(dout), int'(e.d));
        chk("rd_latency", cyc, e.c);
      end
    end
  end

  task automatic tick(input logic w, input logic [7:0] d,
                      input logic r, input logic [7:0] e,
                      input logic fl = 1'b0, input logic clr = 1'b0,
                      input logic rst = 1'b0);
    exp_t x;
    wr = w; din = d; rd = r;
    flush = fl; clr_ovf = clr; reset = rst;
    if (r && !fl && !rst) begin
      x.d = e;
      x.c = cyc + 1;
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    wr = 0; rd = 0; flush = 0; clr_ovf = 0; reset = 0;
  endtask

  task automatic wbyte(input logic [7:0] d);
    tick(1'b1, d, 1'b0, 8'h00);
  endtask

  task automatic rbyte(input logic [7:0] e);
    tick(1'b0, 8'h00, 1'b1, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wr = 0; din = 0; rd = 0; flush = 0; clr_ovf = 0; reset = 1;
    @(posedge clk); #1;
    tick(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // 1: reset state, three bytes in order
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_afull", int'(afull), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_data", int'(dout), 0);
    chk("rst_valid", int'(dvalid), 0);
    wbyte(8'h41);
    chk("t1_not_empty", int'(empty), 0);
    wbyte(8'h42);
    wbyte(8'h43);
    chk("t1_count3", int'(count), 3);
    rbyte(8'h41);
    rbyte(8'h42);
    rbyte(8'h43);
    chk("t1_empty_end", int'(empty), 1);

    // 2: fill, overflow, drain, clear
    for (int i = 0; i < 16; i++) begin
      wbyte(8'(i));
      if (i == 10) chk("t2_af_at11", int'(afull), 0);
      if (i == 11) chk("t2_af_at12", int'(afull), 1);
      if (i == 14) chk("t2_notfull15", int'(full), 0);
    end
    chk("t2_full", int'(full), 1);
    chk("t2_count16", int'(count), 16);
    chk("t2_ovf_before", int'(ovf), 0);
    wbyte(8'h10);
    chk("t2_ovf_set", int'(ovf), 1);
    chk("t2_count_hold", int'(count), 16);
    for (int i = 0; i < 16; i++) rbyte(8'(i));
    chk("t2_empty", int'(empty), 1);
    chk("t2_ovf_sticky", int'(ovf), 1);
    tick(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("t2_ovf_clr", int'(ovf), 0);

    // 3: read empty; write+read on empty
    rbyte(8'h00);
    chk("t3_count0", int'(count), 0);
    tick(1'b1, 8'h55, 1'b1, 8'h00);
    chk("t3_wr_rd_empty_cnt", int'(count), 1);
    rbyte(8'h55);
    chk("t3_count_back0", int'(count), 0);

    // 4: full with write+read, then wrap
    for (int i = 0; i < 16; i++) wbyte(8'h80 + 8'(i));
    tick(1'b1, 8'hAA, 1'b1, 8'h80);
    chk("t4_count16", int'(count), 16);
    chk("t4_no_ovf", int'(ovf), 0);
    chk("t4_full", int'(full), 1);
    for (int k = 0; k < 20; k++) begin
      logic [7:0] e;
      if (k < 15) e = 8'h81 + 8'(k);
      else if (k == 15) e = 8'hAA;
      else e = 8'hC0 + 8'(k - 16);
      tick(1'b1, 8'hC0 + 8'(k), 1'b1, e);
    end
    chk("t4_count_wrap", int'(count), 16);
    chk("t4_no_ovf_wrap", int'(ovf), 0);
    for (int j = 0; j < 16; j++) rbyte(8'hC4 + 8'(j));
    chk("t4_empty", int'(empty), 1);

    // 5: flush with write, then reset mid-operation
    for (int i = 0; i < 5; i++) wbyte(8'h20 + 8'(i));
    chk("t5_count5", int'(count), 5);
    tick(1'b1, 8'hEE, 1'b0, 8'h00, 1'b1);
    chk("t5_flush_cnt", int'(count), 0);
    chk("t5_flush_empty", int'(empty), 1);
    chk("t5_flush_ovf", int'(ovf), 0);
    for (int i = 0; i < 10; i++) wbyte(8'h30 + 8'(i));
    rbyte(8'h30);
    chk("t5_count9", int'(count), 9);
    chk("t5_data_pre", int'(dout), 8'h30);
    tick(1'b1, 8'h99, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t5_rst_count", int'(count), 0);
    chk("t5_rst_empty", int'(empty), 1);
    chk("t5_rst_full", int'(full), 0);
    chk("t5_rst_afull", int'(afull), 0);
    chk("t5_rst_data", int'(dout), 0);
    chk("t5_rst_valid", int'(dvalid), 0);
    chk("t5_rst_ovf", int'(ovf), 0);

`ifdef UART_RX_FIFO_FLOW_EN
    // 6: RTS hysteresis
    chk("t6_rts_rst", int'(rts), 0);
    for (int i = 0; i < 12; i++) begin
      wbyte(8'h60 + 8'(i));
      if (i == 10) chk("t6_rts_at11", int'(rts), 0);
    end
    chk("t6_rts_at12", int'(rts), 1);
    for (int i = 0; i < 5; i++) rbyte(8'h60 + 8'(i));
    chk("t6_rts_at7", int'(rts), 1);
    rbyte(8'h65);
    chk("t6_rts_at6", int'(rts), 0);
    for (int i = 6; i < 12; i++) rbyte(8'h60 + 8'(i));
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
